// File: rtl/rxx_tap_collector_pkg.sv
// Shared constants and types for the autocorrelation tap collector.
// Module parameters default to the values here.
package rxx_tap_collector_pkg;

  localparam int L_DEF        = 7;
  localparam int VAL_SIZE_DEF = 16;
  localparam int NUM_TAPS     = 2 * L_DEF + 1;
  localparam int IDX_W        = $clog2(NUM_TAPS);

  typedef enum logic {
    SEEK = 1'b0,
    FILL = 1'b1
  } state_t;

  typedef logic signed [VAL_SIZE_DEF-1:0] tap_t;

endpackage

// File: rtl/rxx_tap_bank.sv
// Tap register array with single-entry write, whole-bank load and a registered
// read port. Bulk load wins over the single write on the same edge.
module rxx_tap_bank
  import rxx_tap_collector_pkg::*;
#(
  parameter int TAPS     = NUM_TAPS,
  parameter int VAL_SIZE = VAL_SIZE_DEF,
  parameter int ADDR_W   = $clog2(TAPS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic signed [VAL_SIZE-1:0] wr_data,
  input  logic                       load_en,
  input  logic [TAPS*VAL_SIZE-1:0]   load_data,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic signed [VAL_SIZE-1:0] rd_data,
  output logic [TAPS*VAL_SIZE-1:0]   contents
);

  logic signed [VAL_SIZE-1:0] mem [TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (load_en) begin
        for (int i = 0; i < TAPS; i++) mem[i] <= load_data[i*VAL_SIZE +: VAL_SIZE];
      end else if (wr_en) begin
        mem[wr_addr] <= wr_data;
      end
      // Addresses past the last tap read as zero.
      rd_data <= (int'(rd_addr) < TAPS) ? mem[rd_addr] : '0;
    end
  end

  always_comb begin
    contents = '0;
    for (int i = 0; i < TAPS; i++) contents[i*VAL_SIZE +: VAL_SIZE] = mem[i];
  end

endmodule

// File: rtl/rxx_tap_collector.sv
// Collects the rotating smoothed taps into a shadow bank and publishes each
// complete sweep as a frozen frame behind a valid/ready handshake.
module rxx_tap_collector
  import rxx_tap_collector_pkg::*;
#(
  parameter int L        = L_DEF,
  parameter int VAL_SIZE = VAL_SIZE_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         sync,
  input  logic signed [VAL_SIZE-1:0]   in,
  output logic                         frame_valid,
  input  logic                         frame_ready,
  input  logic [$clog2(2*L+1)-1:0]     rd_addr,
  output logic signed [VAL_SIZE-1:0]   rd_data,
  output logic                         overrun,
  output logic                         resync_err,
  input  logic                         clr_err
);

  localparam int TAP_N = 2 * L + 1;
  localparam int AW    = $clog2(TAP_N);
  localparam logic [AW-1:0] LAST = AW'(TAP_N - 1);

  state_t                     state_p0, state_nxt;
  logic [AW-1:0]              idx_p0, idx_nxt;
  logic                       frame_valid_p0, overrun_p0, resync_err_p0;
  logic                       tap_wr, sweep_done, resync;
  logic                       bank_free, load, drop;
  logic [AW-1:0]              wr_addr;
  logic [TAP_N*VAL_SIZE-1:0]  shadow_flat, load_flat, out_flat_unused;
  logic signed [VAL_SIZE-1:0] shadow_rd_unused;

  always_comb begin
    state_nxt  = state_p0;
    idx_nxt    = idx_p0;
    tap_wr     = 1'b0;
    wr_addr    = '0;
    sweep_done = 1'b0;
    resync     = 1'b0;
    if (en) begin
      unique case (state_p0)
        SEEK: begin
          if (sync) begin
            tap_wr    = 1'b1;
            idx_nxt   = AW'(1);
            state_nxt = FILL;
          end
        end
        FILL: begin
          tap_wr = 1'b1;
          if (sync) begin
            // A sync anywhere but tap 0 abandons the partial sweep.
            resync  = (idx_p0 != '0);
            idx_nxt = AW'(1);
          end else begin
            wr_addr = idx_p0;
            if (idx_p0 == LAST) begin
              sweep_done = 1'b1;
              idx_nxt    = '0;
            end else begin
              idx_nxt = idx_p0 + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bank_free = !frame_valid_p0 || frame_ready;
  assign load      = sweep_done && bank_free;
  assign drop      = sweep_done && !bank_free;

  // The last tap lands in the shadow on the load edge, so splice it in here.
  always_comb begin
    load_flat = shadow_flat;
    load_flat[(TAP_N-1)*VAL_SIZE +: VAL_SIZE] = in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0       <= SEEK;
      idx_p0         <= '0;
      frame_valid_p0 <= 1'b0;
      overrun_p0     <= 1'b0;
      resync_err_p0  <= 1'b0;
    end else begin
      state_p0 <= state_nxt;
      idx_p0   <= idx_nxt;
      if (load)             frame_valid_p0 <= 1'b1;
      else if (frame_ready) frame_valid_p0 <= 1'b0;
      if (drop)             overrun_p0 <= 1'b1;
      else if (clr_err)     overrun_p0 <= 1'b0;
      if (resync)           resync_err_p0 <= 1'b1;
      else if (clr_err)     resync_err_p0 <= 1'b0;
    end
  end

  assign frame_valid = frame_valid_p0;
  assign overrun     = overrun_p0;
  assign resync_err  = resync_err_p0;

  rxx_tap_bank #(.TAPS(TAP_N), .VAL_SIZE(VAL_SIZE), .ADDR_W(AW)) u_shadow (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (tap_wr),
    .wr_addr   (wr_addr),
    .wr_data   (in),
    .load_en   (1'b0),
    .load_data ('0),
    .rd_addr   ('0),
    .rd_data   (shadow_rd_unused),
    .contents  (shadow_flat)
  );

  rxx_tap_bank #(.TAPS(TAP_N), .VAL_SIZE(VAL_SIZE), .ADDR_W(AW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (1'b0),
    .wr_addr   ('0),
    .wr_data   ('0),
    .load_en   (load),
    .load_data (load_flat),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .contents  (out_flat_unused)
  );

endmodule

// File: tb/tb_rxx_tap_collector.sv
// Directed bench for rxx_tap_collector: reset, publish, overrun, handshake,
// resync and mid-sweep reset scenarios with hand-computed expectations.
module tb_rxx_tap_collector;
  import rxx_tap_collector_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, sync_i, frame_ready, clr_err;
  logic [15:0] in_i;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        frame_valid, overrun, resync_err;
  logic [15:0] rv;
  int          pass_cnt = 0;
  int          total    = 0;

  always #5 clk = ~clk;

  rxx_tap_collector dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .sync        (sync_i),
    .in          (in_i),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .overrun     (overrun),
    .resync_err  (resync_err),
    .clr_err     (clr_err)
  );

  task automatic strobe(input logic s, input logic [15:0] v, input logic rdy, input logic clr);
    @(negedge clk);
    en = 1'b1; sync_i = s; in_i = v; frame_ready = rdy; clr_err = clr;
    @(posedge clk); #1;
    en = 1'b0; sync_i = 1'b0; frame_ready = 1'b0; clr_err = 1'b0;
  endtask

  task automatic idle_cycle(input logic rdy, input logic clr);
    @(negedge clk);
    frame_ready = rdy; clr_err = clr;
    @(posedge clk); #1;
    frame_ready = 1'b0; clr_err = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, output logic [15:0] d);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk); #1;
    d = rd_data;
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    total++; if (frame_valid !== 1'b0) $display("FAIL rst_fv: got %b expected 0", frame_valid); else pass_cnt++;
    total++; if (overrun !== 1'b0) $display("FAIL rst_ovr: got %b expected 0", overrun); else pass_cnt++;
    total++; if (resync_err !== 1'b0) $display("FAIL rst_rerr: got %b expected 0", resync_err); else pass_cnt++;
    total++; if (rd_data !== 16'h0000) $display("FAIL rst_rd: got %h expected 0000", rd_data); else pass_cnt++;
    for (int i = 0; i < 3; i++) strobe(1'b0, 16'h1111, 1'b0, 1'b0);
    total++; if (dut.state_p0 !== SEEK) $display("FAIL seek_state: got %0d expected %0d", dut.state_p0, SEEK); else pass_cnt++;
    total++; if (frame_valid !== 1'b0) $display("FAIL seek_fv: got %b expected 0", frame_valid); else pass_cnt++;
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), rv);
      total++; if (rv !== 16'h0000) $display("FAIL seek_rd[%0d]: got %h expected 0000", a, rv); else pass_cnt++;
    end
  endtask

  task automatic test_first_frame;
    for (int i = 0; i < 15; i++) begin
      strobe(i == 0, 16'(i + 1), 1'b0, 1'b0);
      if (i == 13) begin
        total++; if (frame_valid !== 1'b0) $display("FAIL ff_early_fv: got %b expected 0", frame_valid); else pass_cnt++;
      end
    end
    total++; if (frame_valid !== 1'b1) $display("FAIL ff_fv: got %b expected 1", frame_valid); else pass_cnt++;
    for (int a = 0; a < 16; a++) begin
      do_read(4'(a), rv);
      total++;
      if (rv !== ((a < 15) ? 16'(a + 1) : 16'h0000))
        $display("FAIL ff_rd[%0d]: got %h expected %h", a, rv, (a < 15) ? 16'(a + 1) : 16'h0000);
      else pass_cnt++;
    end
  endtask

  task automatic test_overrun;
    for (int i = 0; i < 15; i++) strobe(i == 0, 16'h0100 + 16'(i), 1'b0, 1'b0);
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b expected 1", overrun); else pass_cnt++;
    total++; if (frame_valid !== 1'b1) $display("FAIL ovr_fv: got %b expected 1", frame_valid); else pass_cnt++;
    for (int a = 0; a < 15; a++) begin
      do_read(4'(a), rv);
      total++; if (rv !== 16'(a + 1)) $display("FAIL ovr_rd[%0d]: got %h expected %h", a, rv, 16'(a + 1)); else pass_cnt++;
    end
    idle_cycle(1'b0, 1'b1);
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clr: got %b expected 0", overrun); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk); rd_addr = 4'd0;
    for (int i = 0; i < 15; i++) strobe(i == 0, 16'h0200 + 16'(i), i == 14, 1'b0);
    total++; if (rd_data !== 16'h0001) $display("FAIL b2b_preload_rd: got %h expected 0001", rd_data); else pass_cnt++;
    total++; if (frame_valid !== 1'b1) $display("FAIL b2b_fv: got %b expected 1", frame_valid); else pass_cnt++;
    total++; if (overrun !== 1'b0) $display("FAIL b2b_ovr: got %b expected 0", overrun); else pass_cnt++;
    for (int a = 0; a < 15; a++) begin
      do_read(4'(a), rv);
      total++; if (rv !== 16'h0200 + 16'(a)) $display("FAIL b2b_rd[%0d]: got %h expected %h", a, rv, 16'h0200 + 16'(a)); else pass_cnt++;
    end
    idle_cycle(1'b1, 1'b0);
    total++; if (frame_valid !== 1'b0) $display("FAIL consume_fv: got %b expected 0", frame_valid); else pass_cnt++;
  endtask

  task automatic test_resync;
    for (int i = 0; i < 5; i++) strobe(i == 0, 16'h3000 + 16'(i), 1'b0, 1'b0);
    strobe(1'b1, 16'h7FFF, 1'b0, 1'b0);
    total++; if (resync_err !== 1'b1) $display("FAIL rs_err: got %b expected 1", resync_err); else pass_cnt++;
    total++; if (frame_valid !== 1'b0) $display("FAIL rs_partial_fv: got %b expected 0", frame_valid); else pass_cnt++;
    for (int i = 0; i < 14; i++) strobe(1'b0, 16'h8000 + 16'(i), 1'b0, 1'b0);
    total++; if (frame_valid !== 1'b1) $display("FAIL rs_fv: got %b expected 1", frame_valid); else pass_cnt++;
    for (int a = 0; a < 15; a++) begin
      do_read(4'(a), rv);
      total++;
      if (rv !== ((a == 0) ? 16'h7FFF : 16'h8000 + 16'(a - 1)))
        $display("FAIL rs_rd[%0d]: got %h expected %h", a, rv, (a == 0) ? 16'h7FFF : 16'h8000 + 16'(a - 1));
      else pass_cnt++;
    end
    idle_cycle(1'b0, 1'b1);
    total++; if (resync_err !== 1'b0) $display("FAIL rs_clr: got %b expected 0", resync_err); else pass_cnt++;
    strobe(1'b1, 16'h4000, 1'b0, 1'b0);
    strobe(1'b0, 16'h4001, 1'b0, 1'b0);
    strobe(1'b1, 16'h4002, 1'b0, 1'b1);
    total++; if (resync_err !== 1'b1) $display("FAIL rs_set_prio: got %b expected 1", resync_err); else pass_cnt++;
    idle_cycle(1'b0, 1'b1);
    total++; if (resync_err !== 1'b0) $display("FAIL rs_clr2: got %b expected 0", resync_err); else pass_cnt++;
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 8; i++) strobe(1'b0, 16'h6000 + 16'(i), 1'b0, 1'b0);
    total++; if (dut.idx_p0 !== 4'd9) $display("FAIL mr_idx_pre: got %0d expected 9", dut.idx_p0); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; en = 1'b1; sync_i = 1'b1; in_i = 16'h5555; rd_addr = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; sync_i = 1'b0;
    total++; if (frame_valid !== 1'b0) $display("FAIL mr_fv: got %b expected 0", frame_valid); else pass_cnt++;
    total++; if (rd_data !== 16'h0000) $display("FAIL mr_rd: got %h expected 0000", rd_data); else pass_cnt++;
    total++; if (dut.state_p0 !== SEEK) $display("FAIL mr_state: got %0d expected %0d", dut.state_p0, SEEK); else pass_cnt++;
    total++; if (dut.idx_p0 !== 4'd0) $display("FAIL mr_idx: got %0d expected 0", dut.idx_p0); else pass_cnt++;
    for (int a = 0; a < 15; a++) begin
      do_read(4'(a), rv);
      total++; if (rv !== 16'h0000) $display("FAIL mr_bank[%0d]: got %h expected 0000", a, rv); else pass_cnt++;
    end
    for (int i = 0; i < 15; i++) strobe(i == 0, 16'h5000 + 16'(i), 1'b0, 1'b0);
    total++; if (frame_valid !== 1'b1) $display("FAIL mr_new_fv: got %b expected 1", frame_valid); else pass_cnt++;
    for (int a = 0; a < 15; a++) begin
      do_read(4'(a), rv);
      total++; if (rv !== 16'h5000 + 16'(a)) $display("FAIL mr_new_rd[%0d]: got %h expected %h", a, rv, 16'h5000 + 16'(a)); else pass_cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync_i = 1'b0; frame_ready = 1'b0; clr_err = 1'b0;
    in_i = 16'h0000; rd_addr = 4'd0;
    test_reset();
    test_first_frame();
    test_overrun();
    test_back_to_back();
    test_resync();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
